mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the 5-stage pipeline, between execute and write_back.
- Accepts one instruction per handshake from execute and performs loads and stores on a single-port data memory with variable wait states.
- Load data is aligned and sign/zero-extended.
- Registered MEM/WB outputs (Rmem, Wreg, result, memOut, rd) feed write_back directly.

Parameters:
- ADDR_W, 32, data-memory byte-address width (dmem_addr width).

Ports:
- clk  in  1  clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept (state IDLE).
- ex_result  in  32  ALU result; the effective byte address for memory ops.
- ex_store_data  in  32  rs2 value for stores.
- ex_Rmem  in  1  load.
- ex_Wmem  in  1  store.
- ex_Wreg  in  1  writes rd.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  memory request, held until dmem_ready.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ready  in  1  access completes this cycle; rdata valid for loads.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  MEM/WB register holds a new instruction this cycle (one-cycle pulse).
- Rmem  out  1  to write_back.
- Wreg  out  1  to write_back.
- result  out  32  to write_back.
- memOut  out  32  to write_back; extended load data.
- rd  out  5  to write_back.
- mem_err  out  1  one-cycle pulse: misaligned access or illegal funct3.

Behaviour:
- Reset (asynchronous, n_reset=0):
  - state=IDLE.
  - All outputs 0 except ex_ready=1.
  - Any outstanding dmem_req is dropped immediately; the bench does not expect completion.
- FSM states: IDLE, ACCESS.
- ex_ready=1 only in IDLE. A transfer occurs when ex_valid & ex_ready at a rising edge.
- Non-memory op (ex_Rmem=0, ex_Wmem=0):
  - Next cycle: wb_valid=1, result=ex_result, Wreg=ex_Wreg, rd=ex_rd, Rmem=0, memOut=0.
  - Latency 1; back-to-back transfers every cycle.
- Legality check at accept:
  - Illegal if ex_Rmem & ex_Wmem.
  - Illegal if funct3 not in {000,001,010,100,101}.
  - Illegal if H/HU with addr[0]=1.
  - Illegal if W with addr[1:0]!=0.
  - Stores accept only 000/001/010.
- Illegal memory op:
  - No dmem_req issued.
  - Next cycle: wb_valid=1 and mem_err=1, with Wreg=0, Rmem=0, memOut=0; result and rd are passed through.
  - State stays IDLE.
- Legal memory op: enter ACCESS on the accept edge.
  - In ACCESS: dmem_req=1, and dmem_addr, dmem_we, dmem_be, dmem_wdata are registered and held stable until dmem_ready.
  - dmem_be: B gives 0001<<addr[1:0]; H gives 0011<<addr[1:0]; W gives 1111. For loads dmem_be carries the same pattern.
  - dmem_wdata: store byte replicated to all 4 lanes for B; halfword replicated to both halves for H; the full word for W.
  - When dmem_ready=1 in ACCESS: MEM/WB register loads at that edge, state returns to IDLE. Next cycle wb_valid=1.
  - Minimum load/store latency: accept at edge N, dmem_req high during cycle N+1. If ready then, wb_valid is seen in cycle N+2.
  - dmem_req deasserts in the cycle after ready.
  - Loads: select lane by addr[1:0] (B/BU) or addr[1] (H/HU). B/H sign-extend; BU/HU zero-extend. Results: memOut=extended data, Rmem=1, Wreg=ex_Wreg.
  - Stores: Wreg=0, Rmem=0, memOut=0.
  - result always equals the captured ex_result.
- wb_valid=0 cycles:
  - Rmem, Wreg, result, memOut and rd keep their last values.
  - write_back qualifies its write with wb_valid, so Wreg is also forced to 0 while wb_valid=0.
- Edge cases:
  - dmem_ready while in IDLE is ignored.
  - ex_valid while in ACCESS is not accepted; execute must hold its inputs.
  - Reset during ACCESS returns to IDLE with no wb_valid pulse.

Test Plan:
- ALU pass-through: ADD with result=0x0000_1234, rd=5, Wreg=1, three back-to-back ops -> wb_valid on 3 consecutive cycles; result=0x1234, rd=5, Wreg=1, Rmem=0; ex_ready held 1.
- LB sign-extend: addr=0x0000_0103, funct3=000, rdata=0x80FF_7F01, ready after 3 wait cycles -> dmem_addr=0x100, be=1000, req held 4 cycles; memOut=0xFFFF_FF80, Rmem=1; ex_ready=0 throughout ACCESS.
- LHU and LW: addr=0x202 with HU, rdata=0xBEEF_0000 -> memOut=0x0000_BEEF. Addr=0x204 with W, rdata=0xDEAD_BEEF -> memOut=0xDEAD_BEEF.
- SB/SH: SB to addr=0x301 with data=0x0000_00A5 -> be=0010, wdata=0xA5A5_A5A5, we=1, Wreg=0 at WB. SH to 0x302 with data=0x1234 -> be=1100, wdata=0x1234_1234.
- Errors: LW at 0x102 -> no dmem_req, mem_err=1, wb_valid=1, Wreg=0. Load with funct3=011 -> same response. Rmem=Wmem=1 -> same response.
- Reset mid-access: LW issued, n_reset low for 1 cycle while dmem_req=1 -> dmem_req=0 immediately, ex_ready=1, no wb_valid. After release, a new ADD completes with latency 1.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage: accepts one instruction from execute, runs loads/stores on a
// single-port data memory with wait states, and drives the registered MEM/WB outputs.
module mem_access #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_result,
   input  logic [31:0]       ex_store_data,
   input  logic              ex_Rmem,
   input  logic              ex_Wmem,
   input  logic              ex_Wreg,
   input  logic [4:0]        ex_rd,
   input  logic [2:0]        ex_funct3,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic              Rmem,
   output logic              Wreg,
   output logic [31:0]       result,
   output logic [31:0]       memOut,
   output logic [4:0]        rd,
   output logic              mem_err
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic access_legal(input logic rmem_i, input logic wmem_i,
                                         input logic [2:0] f3, input logic [1:0] lo);
      logic ok;
      ok = 1'b0;
      if (rmem_i && wmem_i) begin
         ok = 1'b0;
      end else begin
         case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = rmem_i;
            F3_HU:   ok = rmem_i & ~lo[0];
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] lo);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = 4'b0011 << lo;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicating the narrow datum into every lane lets the byte enables do the selection.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] ext;
      case (lo)
         2'b00:   byte_v = word[7:0];
         2'b01:   byte_v = word[15:8];
         2'b10:   byte_v = word[23:16];
         2'b11:   byte_v = word[31:24];
         default: byte_v = 8'h00;
      endcase
      if (lo[1]) begin
         half_v = word[31:16];
      end else begin
         half_v = word[15:0];
      end
      case (f3)
         F3_B:    ext = {{24{byte_v[7]}}, byte_v};
         F3_H:    ext = {{16{half_v[15]}}, half_v};
         F3_W:    ext = word;
         F3_BU:   ext = {24'h000000, byte_v};
         F3_HU:   ext = {16'h0000, half_v};
         default: ext = 32'h0000_0000;
      endcase
      return ext;
   endfunction

   state_t state_r, state_nxt_s;

   logic              ex_ready_r, ex_ready_nxt_s;
   logic              req_r, req_nxt_s;
   logic              we_r, we_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [3:0]        be_r, be_nxt_s;
   logic [31:0]       wdata_r, wdata_nxt_s;

   logic              wb_valid_r, wb_valid_nxt_s;
   logic              rmem_r, rmem_nxt_s;
   logic              wreg_r, wreg_nxt_s;
   logic [31:0]       result_r, result_nxt_s;
   logic [31:0]       mem_out_r, mem_out_nxt_s;
   logic [4:0]        rd_r, rd_nxt_s;
   logic              mem_err_r, mem_err_nxt_s;

   logic [31:0]       cap_result_r, cap_result_nxt_s;
   logic [4:0]        cap_rd_r, cap_rd_nxt_s;
   logic              cap_wreg_r, cap_wreg_nxt_s;
   logic              cap_load_r, cap_load_nxt_s;
   logic [2:0]        cap_f3_r, cap_f3_nxt_s;
   logic [1:0]        cap_lo_r, cap_lo_nxt_s;

   logic              mem_op_s;
   logic              legal_s;

   // Next-state and next-output logic for the stage.
   always_comb begin
      state_nxt_s      = state_r;
      req_nxt_s        = req_r;
      we_nxt_s         = we_r;
      addr_nxt_s       = addr_r;
      be_nxt_s         = be_r;
      wdata_nxt_s      = wdata_r;
      wb_valid_nxt_s   = 1'b0;
      rmem_nxt_s       = rmem_r;
      wreg_nxt_s       = 1'b0;
      result_nxt_s     = result_r;
      mem_out_nxt_s    = mem_out_r;
      rd_nxt_s         = rd_r;
      mem_err_nxt_s    = 1'b0;
      cap_result_nxt_s = cap_result_r;
      cap_rd_nxt_s     = cap_rd_r;
      cap_wreg_nxt_s   = cap_wreg_r;
      cap_load_nxt_s   = cap_load_r;
      cap_f3_nxt_s     = cap_f3_r;
      cap_lo_nxt_s     = cap_lo_r;
      mem_op_s         = ex_Rmem | ex_Wmem;
      legal_s          = access_legal(ex_Rmem, ex_Wmem, ex_funct3, ex_result[1:0]);

      case (state_r)
         IDLE: begin
            if (ex_valid && !mem_op_s) begin
               wb_valid_nxt_s = 1'b1;
               result_nxt_s   = ex_result;
               wreg_nxt_s     = ex_Wreg;
               rd_nxt_s       = ex_rd;
               rmem_nxt_s     = 1'b0;
               mem_out_nxt_s  = 32'h0000_0000;
            end else if (ex_valid && !legal_s) begin
               wb_valid_nxt_s = 1'b1;
               mem_err_nxt_s  = 1'b1;
               result_nxt_s   = ex_result;
               wreg_nxt_s     = 1'b0;
               rd_nxt_s       = ex_rd;
               rmem_nxt_s     = 1'b0;
               mem_out_nxt_s  = 32'h0000_0000;
            end else if (ex_valid) begin
               state_nxt_s      = ACCESS;
               req_nxt_s        = 1'b1;
               we_nxt_s         = ex_Wmem;
               addr_nxt_s       = {ex_result[ADDR_W-1:2], 2'b00};
               be_nxt_s         = calc_be(ex_funct3, ex_result[1:0]);
               wdata_nxt_s      = store_lanes(ex_funct3, ex_store_data);
               cap_result_nxt_s = ex_result;
               cap_rd_nxt_s     = ex_rd;
               cap_wreg_nxt_s   = ex_Wreg;
               cap_load_nxt_s   = ex_Rmem;
               cap_f3_nxt_s     = ex_funct3;
               cap_lo_nxt_s     = ex_result[1:0];
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            if (dmem_ready) begin
               state_nxt_s    = IDLE;
               req_nxt_s      = 1'b0;
               wb_valid_nxt_s = 1'b1;
               result_nxt_s   = cap_result_r;
               rd_nxt_s       = cap_rd_r;
               rmem_nxt_s     = cap_load_r;
               if (cap_load_r) begin
                  wreg_nxt_s    = cap_wreg_r;
                  mem_out_nxt_s = load_extend(cap_f3_r, cap_lo_r, dmem_rdata);
               end else begin
                  wreg_nxt_s    = 1'b0;
                  mem_out_nxt_s = 32'h0000_0000;
               end
            end else begin
               state_nxt_s = ACCESS;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
         end
      endcase

      ex_ready_nxt_s = (state_nxt_s == IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered memory-request, MEM/WB and capture registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         ex_ready_r   <= 1'b1;
         req_r        <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         be_r         <= 4'b0000;
         wdata_r      <= 32'h0000_0000;
         wb_valid_r   <= 1'b0;
         rmem_r       <= 1'b0;
         wreg_r       <= 1'b0;
         result_r     <= 32'h0000_0000;
         mem_out_r    <= 32'h0000_0000;
         rd_r         <= 5'd0;
         mem_err_r    <= 1'b0;
         cap_result_r <= 32'h0000_0000;
         cap_rd_r     <= 5'd0;
         cap_wreg_r   <= 1'b0;
         cap_load_r   <= 1'b0;
         cap_f3_r     <= 3'b000;
         cap_lo_r     <= 2'b00;
      end else begin
         ex_ready_r   <= ex_ready_nxt_s;
         req_r        <= req_nxt_s;
         we_r         <= we_nxt_s;
         addr_r       <= addr_nxt_s;
         be_r         <= be_nxt_s;
         wdata_r      <= wdata_nxt_s;
         wb_valid_r   <= wb_valid_nxt_s;
         rmem_r       <= rmem_nxt_s;
         wreg_r       <= wreg_nxt_s;
         result_r     <= result_nxt_s;
         mem_out_r    <= mem_out_nxt_s;
         rd_r         <= rd_nxt_s;
         mem_err_r    <= mem_err_nxt_s;
         cap_result_r <= cap_result_nxt_s;
         cap_rd_r     <= cap_rd_nxt_s;
         cap_wreg_r   <= cap_wreg_nxt_s;
         cap_load_r   <= cap_load_nxt_s;
         cap_f3_r     <= cap_f3_nxt_s;
         cap_lo_r     <= cap_lo_nxt_s;
      end
   end

   assign ex_ready   = ex_ready_r;
   assign dmem_req   = req_r;
   assign dmem_we    = we_r;
   assign dmem_addr  = addr_r;
   assign dmem_be    = be_r;
   assign dmem_wdata = wdata_r;
   assign wb_valid   = wb_valid_r;
   assign Rmem       = rmem_r;
   assign Wreg       = wreg_r;
   assign result     = result_r;
   assign memOut     = mem_out_r;
   assign rd         = rd_r;
   assign mem_err    = mem_err_r;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: pass-through, loads, stores,
// illegal accesses and reset during an access.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_result;
   logic [31:0] ex_store_data;
   logic        ex_Rmem;
   logic        ex_Wmem;
   logic        ex_Wreg;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic        Rmem;
   logic        Wreg;
   logic [31:0] result;
   logic [31:0] memOut;
   logic [4:0]  rd;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   mem_access #(.ADDR_W(32)) dut (
      .clk(clk), .n_reset(n_reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_store_data(ex_store_data),
      .ex_Rmem(ex_Rmem), .ex_Wmem(ex_Wmem), .ex_Wreg(ex_Wreg),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .Rmem(Rmem), .Wreg(Wreg), .result(result),
      .memOut(memOut), .rd(rd), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rm, input logic wm, input logic wr,
                        input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] sd, input logic [4:0] d);
      ex_valid = v; ex_Rmem = rm; ex_Wmem = wm; ex_Wreg = wr;
      ex_funct3 = f3; ex_result = res; ex_store_data = sd; ex_rd = d;
   endtask

   // Accept the presented memory op, stall 'waits' cycles, then complete it.
   task automatic mem_op(input string tag, input int waits, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic exp_we);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
         chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd0);
         chk({tag, "_addr"}, dmem_addr, exp_addr);
         chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
         chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, exp_we});
         chk({tag, "_wbv_wait"}, {31'd0, wb_valid}, 32'd0);
         dmem_ready = (i == waits);
         tick();
      end
      dmem_ready = 1'b0;
      chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, ex_ready}, 32'd1);
   endtask

   // Issue an illegal op and expect an immediate error write-back.
   task automatic err_op(input string tag);
      tick();
      ex_valid = 1'b0;
      chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, "_err"}, {31'd0, mem_err}, 32'd1);
      chk({tag, "_wreg"}, {31'd0, Wreg}, 32'd0);
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, "_rd"}, {27'd0, rd}, 32'd9);
      chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
      tick();
      chk({tag, "_err_pulse"}, {31'd0, mem_err}, 32'd0);
      chk({tag, "_req_after"}, {31'd0, dmem_req}, 32'd0);
   endtask

   initial begin
      n_reset = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0000_0000;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      #12;
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_err", {31'd0, mem_err}, 32'd0);
      n_reset = 1'b1;
      tick();

      // ALU pass-through, three back-to-back
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("alu_wbv", {31'd0, wb_valid}, 32'd1);
         chk("alu_result", result, 32'h0000_1234);
         chk("alu_rd", {27'd0, rd}, 32'd5);
         chk("alu_wreg", {31'd0, Wreg}, 32'd1);
         chk("alu_rmem", {31'd0, Rmem}, 32'd0);
         chk("alu_ready", {31'd0, ex_ready}, 32'd1);
      end
      ex_valid = 1'b0;
      tick();
      chk("alu_idle_wbv", {31'd0, wb_valid}, 32'd0);
      chk("alu_idle_wreg", {31'd0, Wreg}, 32'd0);
      chk("alu_idle_hold", result, 32'h0000_1234);

      // LB sign-extend, 3 wait states
      dmem_rdata = 32'h80FF_7F01;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
      mem_op("lb", 3, 32'h0000_0100, 4'b1000, 1'b0);
      chk("lb_memout", memOut, 32'hFFFF_FF80);
      chk("lb_rmem", {31'd0, Rmem}, 32'd1);
      chk("lb_wreg", {31'd0, Wreg}, 32'd1);
      chk("lb_rd", {27'd0, rd}, 32'd7);
      chk("lb_result", result, 32'h0000_0103);
      tick();
      chk("lb_after_wreg", {31'd0, Wreg}, 32'd0);
      chk("lb_after_memout", memOut, 32'hFFFF_FF80);

      // LHU
      dmem_rdata = 32'hBEEF_0000;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0202, 32'h0, 5'd8);
      mem_op("lhu", 0, 32'h0000_0200, 4'b1100, 1'b0);
      chk("lhu_memout", memOut, 32'h0000_BEEF);

      // LW
      dmem_rdata = 32'hDEAD_BEEF;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0, 5'd8);
      mem_op("lw", 1, 32'h0000_0204, 4'b1111, 1'b0);
      chk("lw_memout", memOut, 32'hDEAD_BEEF);

      // SB (ex_Wreg set on purpose: a store must not write rd)
      drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd4);
      tick();
      ex_valid = 1'b0;
      chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      dmem_ready = 1'b1;
      chk("sb_be", {28'd0, dmem_be}, 32'h0000_0002);
      chk("sb_we", {31'd0, dmem_we}, 32'd1);
      chk("sb_addr", dmem_addr, 32'h0000_0300);
      tick();
      dmem_ready = 1'b0;
      chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
      chk("sb_wreg", {31'd0, Wreg}, 32'd0);
      chk("sb_rmem", {31'd0, Rmem}, 32'd0);
      chk("sb_memout", memOut, 32'h0);
      chk("sb_result", result, 32'h0000_0301);

      // SH
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0000_1234, 5'd4);
      tick();
      ex_valid = 1'b0;
      chk("sh_wdata", dmem_wdata, 32'h1234_1234);
      mem_op("sh", 0, 32'h0000_0300, 4'b1100, 1'b1);
      mem_op_cleanup: chk("sh_wreg", {31'd0, Wreg}, 32'd0);

      // Illegal: misaligned LW, bad funct3, load+store
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 5'd9);
      err_op("e_misalign");
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 5'd9);
      err_op("e_funct3");
      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd9);
      err_op("e_both");

      // Reset during ACCESS
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd2);
      tick();
      ex_valid = 1'b0;
      chk("rma_req_before", {31'd0, dmem_req}, 32'd1);
      n_reset = 1'b0;
      #1;
      chk("rma_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("rma_ready", {31'd0, ex_ready}, 32'd1);
      dmem_ready = 1'b1;
      tick();
      chk("rma_no_wbv", {31'd0, wb_valid}, 32'd0);
      dmem_ready = 1'b0;
      n_reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0055, 32'h0, 5'd3);
      tick();
      ex_valid = 1'b0;
      chk("rma_add_wbv", {31'd0, wb_valid}, 32'd1);
      chk("rma_add_result", result, 32'h0000_0055);
      chk("rma_add_rd", {27'd0, rd}, 32'd3);
      tick();
      chk("rma_end_wbv", {31'd0, wb_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
